// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and presents the registered instruction to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_sel,
  input  logic        bgtz_cond,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] npc;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic        commit;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_tgt   = {pc_plus4[31:28], imm26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      2'b00:   npc = pc_plus4;
      2'b01:   npc = jump_tgt;
      2'b11:   npc = branch_tgt;
      2'b10:   npc = bgtz_cond ? branch_tgt : pc_plus4;
      default: npc = pc_plus4;
    endcase
  end

  // The request line is a pure function of state, so it drops in the same
  // edge that captures the acked word.
  assign commit = (state_q == ST_HOLD) && instr_valid_q && !stall;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (im_ack) begin
          instr_d       = im_rdata;
          instr_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (commit) begin
          pc_d          = npc;
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!rst) begin
      state_q       <= ST_RST;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign im_req      = (state_q == ST_FETCH);
  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: handshake timing, every npc rule, stall,
// PC wrap and reset abandoning an in-flight fetch.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        bgtz_cond = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] imm26 = '0;
  logic        stall = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int n_checks = 0;
  int n_errors = 0;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .npc_sel     (npc_sel),
    .bgtz_cond   (bgtz_cond),
    .imm16       (imm16),
    .imm26       (imm26),
    .stall       (stall),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .op          (op),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the request, then acks after
  // wait_cycles idle cycles and checks the captured word one cycle later.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int wait_cycles);
    logic [5:0] exp_op;
    logic [5:0] exp_funct;
    int budget;
    exp_op    = word[31:26];
    exp_funct = word[5:0];
    budget    = 0;
    while (im_req !== 1'b1 && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    check("fetch_req", {31'd0, im_req}, 32'd1);
    check("fetch_addr", im_addr, addr);
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      check("fetch_addr_stable", im_addr, addr);
      check("fetch_wait_invalid", {31'd0, instr_valid}, 32'd0);
    end
    im_ack   = 1'b1;
    im_rdata = word;
    @(negedge clk);
    im_ack   = 1'b0;
    im_rdata = $urandom;
    check("instr", instr, word);
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("req_drop", {31'd0, im_req}, 32'd0);
    check("op", {26'd0, op}, {26'd0, exp_op});
    check("funct", {26'd0, funct}, {26'd0, exp_funct});
    check("pc_hold", pc, addr);
  endtask

  // Called at a negedge in HOLD; drives the npc controls and commits.
  task automatic commit(input logic [1:0] sel, input logic [15:0] i16, input logic [25:0] i26,
                        input logic cond, input logic [31:0] exp_pc);
    npc_sel   = sel;
    imm16     = i16;
    imm26     = i26;
    bgtz_cond = cond;
    stall     = 1'b0;
    @(negedge clk);
    check("npc", pc, exp_pc);
    check("next_im_addr", im_addr, exp_pc);
    check("commit_invalid", {31'd0, instr_valid}, 32'd0);
    check("commit_req", {31'd0, im_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, im_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_op_funct", {20'd0, op, funct}, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'h0000_3004);

    rst = 1'b1;
    do_fetch(32'h0000_3000, 32'h2109_0004, 1);
    commit(2'b00, 16'h0, 26'h0, 1'b0, 32'h0000_3004);

    do_fetch(32'h0000_3004, 32'h0000_0021, 0);
    commit(2'b00, 16'h0, 26'h0, 1'b0, 32'h0000_3008);
    do_fetch(32'h0000_3008, 32'h1000_FFFE, 0);
    commit(2'b11, 16'hFFFE, 26'h0, 1'b0, 32'h0000_3004);
    do_fetch(32'h0000_3004, 32'h0000_0021, 2);
    commit(2'b00, 16'h0, 26'h0, 1'b0, 32'h0000_3008);
    do_fetch(32'h0000_3008, 32'h1000_0003, 0);
    commit(2'b11, 16'h0003, 26'h0, 1'b0, 32'h0000_3018);

    // j back to 0x3000, then bgtz not-taken and taken
    do_fetch(32'h0000_3018, 32'h0800_0C00, 0);
    commit(2'b01, 16'h0, 26'h000_0C00, 1'b0, 32'h0000_3000);
    do_fetch(32'h0000_3000, 32'h1C20_0002, 0);
    commit(2'b10, 16'h0002, 26'h0, 1'b0, 32'h0000_3004);
    do_fetch(32'h0000_3004, 32'h0800_0C00, 0);
    commit(2'b01, 16'h0, 26'h000_0C00, 1'b0, 32'h0000_3000);
    do_fetch(32'h0000_3000, 32'h1C20_0002, 0);
    commit(2'b10, 16'h0002, 26'h0, 1'b1, 32'h0000_300C);
    do_fetch(32'h0000_300C, 32'h0800_0C00, 0);
    commit(2'b01, 16'h0, 26'h000_0C00, 1'b0, 32'h0000_3000);
    do_fetch(32'h0000_3000, 32'h0800_0C10, 0);
    commit(2'b01, 16'h0, 26'h000_0C10, 1'b0, 32'h0000_3040);

    // Stall in HOLD: controls and a stray ack must have no effect
    do_fetch(32'h0000_3040, 32'h8C8A_0010, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      npc_sel   = 2'(i + 1);
      imm16     = 16'h0100;
      imm26     = 26'h3FF_FFFF;
      bgtz_cond = 1'b1;
      im_ack    = 1'b1;
      im_rdata  = 32'h1111_1111;
      @(negedge clk);
      check("stall_instr", instr, 32'h8C8A_0010);
      check("stall_pc", pc, 32'h0000_3040);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, im_req}, 32'd0);
    end
    im_ack = 1'b0;
    commit(2'b11, 16'h0001, 26'h0, 1'b0, 32'h0000_3048);

    // Branch backwards past zero, then sequential wrap to 0
    do_fetch(32'h0000_3048, 32'h0800_0C00, 0);
    commit(2'b01, 16'h0, 26'h000_0C00, 1'b0, 32'h0000_3000);
    do_fetch(32'h0000_3000, 32'h1000_F3FE, 0);
    commit(2'b11, 16'hF3FE, 26'h0, 1'b0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    commit(2'b00, 16'h0, 26'h0, 1'b0, 32'h0000_0000);

    // Reset while a fetch is pending, with a late ack in the same cycle
    check("pre_rst_req", {31'd0, im_req}, 32'd1);
    rst      = 1'b0;
    im_ack   = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    im_ack = 1'b0;
    check("midrst_instr", instr, 32'd0);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_pc", pc, 32'h0000_3000);
    check("midrst_req", {31'd0, im_req}, 32'd0);
    rst = 1'b1;
    do_fetch(32'h0000_3000, 32'h0000_0008, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
